// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg: register offsets, status bit positions and serializer states
package uart_tx_mmio_pkg;
   localparam logic REG_DATA   = 1'b0;
   localparam logic REG_STATUS = 1'b1;
   localparam int ST_FULL      = 0;
   localparam int ST_BUSY      = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_COUNT_LSB = 8;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head; push ignored when full, pop ignored when empty
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [AW:0] cnt_q, cnt_d;
   logic push_ok, pop_ok;
   assign full    = cnt_q == (AW+1)'(DEPTH);
   assign empty   = cnt_q == '0;
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem_q[rd_q];
   assign count   = cnt_q;
   always_comb begin
      wr_d  = push_ok ? wr_q + AW'(1) : wr_q;
      rd_d  = pop_ok ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= din;
      if (reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with byte FIFO and polled status
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int CLKDIV = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        irq_empty
);
   localparam int TW = $clog2(CLKDIV);
   localparam int CW = $clog2(DEPTH) + 1;
   tx_state_e state_q, state_d;
   logic [7:0] sh_q, sh_d, head;
   logic [2:0] bit_q, bit_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic txd_q, txd_d, irq_q, irq_d, ovf_q, ovf_d;
   logic data_wr, stat_wr, pop, full, empty, tmr_last, unused_wdata;
   logic [CW-1:0] count;
   logic [31:0] status;
   assign data_wr      = cs & we & (addr == REG_DATA);
   assign stat_wr      = cs & we & (addr == REG_STATUS);
   assign tmr_last     = tmr_q == TW'(CLKDIV - 1);
   assign unused_wdata = ^wdata[31:8];
   assign txd          = txd_q;
   assign irq_empty    = irq_q;
   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (data_wr),
      .pop   (pop),
      .din   (wdata[7:0]),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      tmr_d   = tmr_q + TW'(1);
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               sh_d    = head;
               state_d = S_START;
            end
         end
         S_START: if (tmr_last) begin
            tmr_d   = '0;
            bit_d   = '0;
            state_d = S_DATA;
         end
         S_DATA: if (tmr_last) begin
            tmr_d   = '0;
            sh_d    = sh_q >> 1;
            bit_d   = bit_q + 3'd1;
            state_d = bit_q == 3'd7 ? S_STOP : S_DATA;
         end
         S_STOP: if (tmr_last) begin
            // chain straight into the next start bit when more data is queued
            tmr_d   = '0;
            pop     = ~empty;
            sh_d    = head;
            state_d = empty ? S_IDLE : S_START;
         end
         default: state_d = S_IDLE;
      endcase
      txd_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? sh_d[0] : 1'b1;
      irq_d = (state_d == S_IDLE) & empty & ~data_wr;
      ovf_d = (ovf_q & ~(stat_wr & wdata[2])) | (data_wr & full);
   end
   always_comb begin
      status                      = '0;
      status[ST_FULL]             = full;
      status[ST_BUSY]             = ~empty | (state_q != S_IDLE);
      status[ST_OVF]              = ovf_q;
      status[ST_COUNT_LSB +: 8]   = 8'(count);
      rdata = (cs && addr == REG_STATUS) ? status : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         bit_q   <= '0;
         tmr_q   <= '0;
         txd_q   <= 1'b1;
         irq_q   <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         tmr_q   <= tmr_d;
         txd_q   <= txd_d;
         irq_q   <= irq_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench with serial-frame decoder checking bytes against a queue of written data
module tb_uart_tx_mmio;
   logic clk = 1'b0, reset = 1'b1, cs = 1'b0, addr = 1'b0, we = 1'b0;
   logic [31:0] wdata = '0, rdata;
   logic txd, irq_empty;
   int tests = 0, fails = 0, nframes = 0, lows = 0;
   logic [7:0] q[$];
   uart_tx_mmio #(.DEPTH(4), .CLKDIV(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .cs        (cs),
      .addr      (addr),
      .we        (we),
      .wdata     (wdata),
      .rdata     (rdata),
      .txd       (txd),
      .irq_empty (irq_empty)
   );
   always #5 clk = ~clk;
   function automatic logic [9:0] frame(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction
   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask
   task automatic wr(input logic a, input logic [31:0] d);
      cs = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0; addr = 1'b0; wdata = '0;
   endtask
   task automatic rd(input logic a, output logic [31:0] v);
      cs = 1'b1; we = 1'b0; addr = a;
      #1 v = rdata;
      cs = 1'b0; addr = 1'b0;
   endtask
   task automatic decode();
      logic in_f = 1'b0;
      int k = 0;
      logic [9:0] fr = '0;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (txd === 1'b0) lows++;
         if (reset) in_f = 1'b0;
         else if (!in_f) begin
            if (txd === 1'b0) begin
               in_f = 1'b1;
               k = 1;
            end
         end else begin
            if (k % 4 == 2) fr = {txd, fr[9:1]};
            if (k == 39) begin
               in_f = 1'b0;
               nframes++;
               tests++;
               assert (q.size() != 0) else begin
                  fails++;
                  $error("FAIL unexpected_frame: observed %h expected none", fr);
               end
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk("frame_bits", 96'(fr), 96'(frame(e)));
               end
            end
            k++;
         end
      end
   endtask
   initial begin
      logic [31:0] v;
      logic [79:0] obs, want;
      logic [9:0] fa, fb;
      int seq[10];
      int l0, f0;
      logic irq_last;
      fork decode(); join_none
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      chk("idle_txd", txd, 1);
      chk("idle_irq", irq_empty, 1);
      rd(1'b1, v);
      chk("idle_status", v, 0);
      chk("idle_no_low", lows, 0);
      // single frame 0x41 with exact bit sequence and timing
      seq = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
      q.push_back(8'h41);
      wr(1'b0, 32'h41);
      chk("w1_txd_before", txd, 1);
      chk("w1_irq_busy", irq_empty, 0);
      rd(1'b1, v);
      chk("w1_status_queued", v, 32'h102);
      @(negedge clk);
      rd(1'b1, v);
      chk("w1_status_popped", v, 32'h002);
      irq_last = 1'b1;
      for (int i = 0; i < 40; i++) begin
         obs[i] = txd;
         want[i] = seq[i/4] != 0;
         irq_last = irq_empty;
         @(negedge clk);
      end
      chk("w1_stream", obs[39:0], want[39:0]);
      chk("w1_irq_in_stop", irq_last, 0);
      chk("w1_irq_after", irq_empty, 1);
      chk("w1_txd_after", txd, 1);
      // back-to-back frames with no idle gap
      fa = frame(8'h48);
      fb = frame(8'h69);
      q.push_back(8'h48);
      q.push_back(8'h69);
      wr(1'b0, 32'h48);
      wr(1'b0, 32'h69);
      rd(1'b1, v);
      chk("b2b_status", v, 32'h102);
      for (int i = 0; i < 80; i++) begin
         obs[i] = txd;
         want[i] = i < 40 ? fa[i/4] : fb[(i-40)/4];
         @(negedge clk);
      end
      chk("b2b_stream", obs, want);
      chk("b2b_irq_after", irq_empty, 1);
      // overflow: 0x30 popped at once, 0x31..0x34 fill, 0x35 dropped
      f0 = nframes;
      for (int i = 0; i < 5; i++) q.push_back(8'(8'h30 + i));
      for (int i = 0; i < 6; i++) wr(1'b0, 32'h30 + 32'(i));
      rd(1'b1, v);
      chk("ovf_status", v, 32'h407);
      wr(1'b1, 32'h4);
      rd(1'b1, v);
      chk("ovf_cleared", v, 32'h403);
      for (int i = 0; i < 400 && !(irq_empty === 1'b1 && q.size() == 0); i++) @(negedge clk);
      @(negedge clk);
      chk("ovf_frames", nframes - f0, 5);
      chk("ovf_queue_drained", q.size(), 0);
      rd(1'b1, v);
      chk("ovf_status_end", v, 0);
      // reset during third data bit of 0x5A
      q.push_back(8'h5A);
      q.push_back(8'hA5);
      wr(1'b0, 32'h5A);
      wr(1'b0, 32'hA5);
      repeat (13) @(negedge clk);
      chk("rst_in_bit2", txd, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_txd", txd, 1);
      chk("rst_irq", irq_empty, 1);
      rd(1'b1, v);
      chk("rst_status", v, 0);
      q.delete();
      l0 = lows;
      f0 = nframes;
      repeat (100) @(negedge clk);
      chk("rst_no_low", lows - l0, 0);
      chk("rst_no_frame", nframes - f0, 0);
      // upper data bits ignored; cs=0 accesses neither push nor read
      f0 = nframes;
      q.push_back(8'h3C);
      wr(1'b0, 32'hABCDEF3C);
      cs = 1'b0; we = 1'b1; addr = 1'b1; wdata = 32'h4;
      #1 chk("cs0_status_rdata", rdata, 0);
      addr = 1'b0; wdata = 32'h55;
      #1 chk("cs0_data_rdata", rdata, 0);
      @(negedge clk);
      we = 1'b0; wdata = '0;
      rd(1'b0, v);
      chk("data_read_zero", v, 0);
      rd(1'b1, v);
      chk("cs0_no_push", v, 32'h002);
      for (int i = 0; i < 100 && irq_empty !== 1'b1; i++) @(negedge clk);
      @(negedge clk);
      chk("cs0_frames", nframes - f0, 1);
      chk("cs0_queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
